// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch (IF) stage of a 5-stage RISC-V pipeline.
//
// It owns the fetch PC, keeps at most one instruction-memory read in flight,
// and fills the IF/ID register. A taken branch or JAL resolved in ID
// redirects fetch and turns IF/ID into a bubble. A word that arrives while ID
// is stalled is parked in a one-entry skid buffer until the stall clears.
//
// Ports:
//   clk          in   1   clock; all state changes on the rising edge
//   rst          in   1   synchronous, active-high reset
//   stall_D      in   1   hazard unit: hold IF/ID and fetch
//   PC_src       in   1   ID branch resolver: redirect to pc_target_d
//   pc_target_d  in   32  branch/JAL target computed in ID
//   imem_req     out  1   read strobe, one-cycle pulse
//   imem_addr    out  32  read address (the fetch PC)
//   imem_rvalid  in   1   read data valid, at least 1 cycle after imem_req
//   imem_rdata   in   32  instruction word
//   instr_d      out  32  IF/ID instruction
//   pc_d         out  32  IF/ID PC
//   pc_plus4_d   out  32  IF/ID PC+4 (JAL link value)
//   valid_d      out  1   IF/ID holds a real instruction
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_D,
  input  logic        PC_src,
  input  logic [31:0] pc_target_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic        kill;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic        redirect;
  logic        accept;
  logic        load_new;
  logic        park;
  logic        load_skid;

  // PC_src is only trusted once ID is not stalled (operands forwarded) and
  // only when IF/ID actually holds the branch that produced it.
  assign redirect  = PC_src & valid_d & ~stall_D;

  // A returning word is usable only if it was not killed by an earlier
  // redirect and is not being overtaken by a redirect right now.
  assign accept    = (state == WAIT) & imem_rvalid & ~kill & ~redirect;
  assign load_new  = accept & ~stall_D;
  assign park      = accept & stall_D;
  assign load_skid = (state == HOLD) & ~stall_D & ~redirect;

  assign imem_req  = (state == ISSUE);
  assign imem_addr = pc_f;

  // ---- fetch control and IF/ID register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_f       <= RESET_PC;
      kill       <= 1'b0;
      instr_d    <= NOP_INSTR;
      pc_d       <= 32'h0000_0000;
      pc_plus4_d <= 32'h0000_0000;
      valid_d    <= 1'b0;
    end else begin
      if (redirect) begin
        pc_f <= pc_target_d;
      end else if (load_new || load_skid) begin
        pc_f <= pc_f + 32'd4;
      end

      // A stall freezes IF/ID; otherwise it takes a new word or a bubble.
      if (load_new) begin
        instr_d    <= imem_rdata;
        pc_d       <= pc_f;
        pc_plus4_d <= pc_f + 32'd4;
        valid_d    <= 1'b1;
      end else if (load_skid) begin
        instr_d    <= skid_instr;
        pc_d       <= skid_pc;
        pc_plus4_d <= skid_pc + 32'd4;
        valid_d    <= 1'b1;
      end else if (!stall_D) begin
        instr_d    <= NOP_INSTR;
        valid_d    <= 1'b0;
      end

      case (state)
        IDLE: state <= ISSUE;
        ISSUE: begin
          // The request still goes out; a redirect now marks its reply stale.
          state <= WAIT;
          kill  <= redirect;
        end
        WAIT: begin
          if (imem_rvalid) begin
            kill  <= 1'b0;
            state <= park ? HOLD : ISSUE;
          end else if (redirect) begin
            kill  <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall_D) state <= ISSUE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- skid buffer (data only, validity tracked by the HOLD state) ----
  always_ff @(posedge clk) begin
    if (park) begin
      skid_instr <= imem_rdata;
      skid_pc    <= pc_f;
    end
  end

endmodule
